mlp_act_stage: RTL and testbench

- Post-MAC output stage of the MLP datapath.
- Consumes each neuron's accumulated Q8.8 result from MLP_mac, adds a per-neuron bias, applies ReLU and saturates the value to DATA_WIDTH.
- Buffers activations in a small output FIFO with valid/ready handshake toward the next layer's input loader.
- Tracks neuron index within the layer and counts saturation events.

---
 rtl/mlp_act_stage_if.sv | 27 ++
 rtl/mlp_act_stage.sv | 179 +++++++++++++++++
 tb/tb_mlp_act_stage.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mlp_act_stage_if.sv
// Streaming interface of mlp_act_stage: accumulator input stream and activation output stream.
// The stage itself uses the slave modport; the producer/consumer side uses master.
interface mlp_act_stage_if #(
   parameter int ACC_WIDTH  = 64,
   parameter int DATA_WIDTH = 16,
   parameter int IDX_W      = 2
);
   logic                         in_valid;
   logic                         in_ready;
   logic signed [ACC_WIDTH-1:0]  in_acc;

   logic                         out_valid;
   logic                         out_ready;
   logic signed [DATA_WIDTH-1:0] out_data;
   logic [IDX_W-1:0]             out_idx;
   logic                         out_last;

   modport master (
      output in_valid, in_acc, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_last
   );

   modport slave (
      input  in_valid, in_acc, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_last
   );
endinterface

// File: rtl/mlp_act_stage.sv
// mlp_act_stage: per-neuron bias add, ReLU with positive saturation, and an output FIFO.
// Define ACT_LEAKY_EN to let negative sums leak with slope 1/8 instead of clamping to zero.
module mlp_act_stage #(
   parameter int  ACC_WIDTH   = 64,
   parameter int  DATA_WIDTH  = 16,
   parameter int  FRAC_BITS   = 8,
   parameter int  NUM_NEURONS = 4,
   parameter int  FIFO_DEPTH  = 4,
   localparam int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   mlp_act_stage_if.slave               bus,
   input  logic                         bias_wr_en,
   input  logic [IDX_W-1:0]             bias_wr_addr,
   input  logic signed [DATA_WIDTH-1:0] bias_wr_data,
   output logic [15:0]                  sat_count,
   input  logic                         sat_clr
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int SUM_W = ACC_WIDTH + 1;
   localparam logic signed [SUM_W-1:0] POS_MAX =
      {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};

   // Bias registers
   logic signed [DATA_WIDTH-1:0] bias_q [NUM_NEURONS];
   logic signed [DATA_WIDTH-1:0] bias_d [NUM_NEURONS];

   // Neuron counter and stage 1
   logic [IDX_W-1:0]       cnt_q, cnt_d;
   logic                   s1_valid_q, s1_valid_d;
   logic signed [SUM_W-1:0] s1_sum_q, s1_sum_d;
   logic [IDX_W-1:0]       s1_idx_q, s1_idx_d;

   // Output FIFO
   logic signed [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
   logic signed [DATA_WIDTH-1:0] mem_data_d [FIFO_DEPTH];
   logic [IDX_W-1:0]             mem_idx_q  [FIFO_DEPTH];
   logic [IDX_W-1:0]             mem_idx_d  [FIFO_DEPTH];
   logic                         mem_last_q [FIFO_DEPTH];
   logic                         mem_last_d [FIFO_DEPTH];
   logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]             rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]             count_q, count_d;

   logic [15:0] sat_count_q, sat_count_d;

   logic                         accept;
   logic                         push;
   logic                         pop;
   logic signed [DATA_WIDTH-1:0] bias_rd;
   logic signed [SUM_W-1:0]      sum;
   logic signed [DATA_WIDTH-1:0] act;
   logic                         sat_evt;

   // in_ready looks only at registered occupancy so it never depends on out_ready.
   assign bus.in_ready = (32'(count_q) + 32'(s1_valid_q)) < 32'(FIFO_DEPTH);
   assign accept       = bus.in_valid && bus.in_ready;
   assign push         = s1_valid_q;
   assign pop          = (count_q != '0) && bus.out_ready;

   assign bias_rd = bias_q[cnt_q];
   assign sum     = {bus.in_acc[ACC_WIDTH-1], bus.in_acc} + SUM_W'(bias_rd);

   assign bus.out_valid = (count_q != '0);
   assign bus.out_data  = mem_data_q[rd_ptr_q];
   assign bus.out_idx   = mem_idx_q[rd_ptr_q];
   assign bus.out_last  = mem_last_q[rd_ptr_q];
   assign sat_count     = sat_count_q;

`ifdef ACT_LEAKY_EN
   localparam logic signed [SUM_W-1:0] NEG_MIN =
      {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
   logic signed [SUM_W-1:0] leak;
   assign leak = s1_sum_q >>> 3;
`endif

   always_comb begin
      act     = s1_sum_q[DATA_WIDTH-1:0];
      sat_evt = 1'b0;
      if (s1_sum_q[SUM_W-1]) begin
`ifdef ACT_LEAKY_EN
         act = (leak < NEG_MIN) ? NEG_MIN[DATA_WIDTH-1:0] : leak[DATA_WIDTH-1:0];
`else
         act = '0;
`endif
      end else if (s1_sum_q > POS_MAX) begin
         act     = POS_MAX[DATA_WIDTH-1:0];
         sat_evt = s1_valid_q;
      end
   end

   // A same-cycle bias write lands in bias_q only after the accept has used the old value.
   always_comb begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
         bias_d[i] = bias_q[i];
         if (bias_wr_en && (bias_wr_addr == IDX_W'(i))) begin
            bias_d[i] = bias_wr_data;
         end
      end
   end

   always_comb begin
      cnt_d      = cnt_q;
      s1_valid_d = accept;
      s1_sum_d   = s1_sum_q;
      s1_idx_d   = s1_idx_q;
      if (accept) begin
         s1_sum_d = sum;
         s1_idx_d = cnt_q;
         cnt_d    = (cnt_q == IDX_W'(NUM_NEURONS - 1)) ? '0 : cnt_q + 1'b1;
      end
   end

   always_comb begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         mem_data_d[i] = mem_data_q[i];
         mem_idx_d[i]  = mem_idx_q[i];
         mem_last_d[i] = mem_last_q[i];
         if (push && (wr_ptr_q == PTR_W'(i))) begin
            mem_data_d[i] = act;
            mem_idx_d[i]  = s1_idx_q;
            mem_last_d[i] = (s1_idx_q == IDX_W'(NUM_NEURONS - 1));
         end
      end
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   // Clear wins over accumulation, but a coincident saturation is still counted.
   always_comb begin
      sat_count_d = sat_count_q;
      if (sat_clr) begin
         sat_count_d = sat_evt ? 16'd1 : 16'd0;
      end else if (sat_evt && (sat_count_q != 16'hFFFF)) begin
         sat_count_d = sat_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            bias_q[i] <= '0;
         end
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_data_q[i] <= '0;
            mem_idx_q[i]  <= '0;
            mem_last_q[i] <= 1'b0;
         end
         cnt_q       <= '0;
         s1_valid_q  <= 1'b0;
         s1_sum_q    <= '0;
         s1_idx_q    <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         sat_count_q <= '0;
      end else begin
         for (int i = 0; i < NUM_NEURONS; i++) begin
            bias_q[i] <= bias_d[i];
         end
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_data_q[i] <= mem_data_d[i];
            mem_idx_q[i]  <= mem_idx_d[i];
            mem_last_q[i] <= mem_last_d[i];
         end
         cnt_q       <= cnt_d;
         s1_valid_q  <= s1_valid_d;
         s1_sum_q    <= s1_sum_d;
         s1_idx_q    <= s1_idx_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         sat_count_q <= sat_count_d;
      end
   end
endmodule

// File: tb/tb_mlp_act_stage.sv
// tb_mlp_act_stage: directed vectors with a scoreboard queue; a monitor pops and compares
// every FIFO transfer. Build with ACT_LEAKY_EN defined to exercise the leaky variant.
module tb_mlp_act_stage;
   localparam int ACC_W = 64;
   localparam int DW    = 16;
   localparam int NN    = 4;
   localparam int DEPTH = 4;
   localparam int IW    = 2;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 bias_wr_en = 1'b0;
   logic [IW-1:0]        bias_wr_addr = '0;
   logic signed [DW-1:0] bias_wr_data = '0;
   logic [15:0]          sat_count;
   logic                 sat_clr = 1'b0;

   mlp_act_stage_if #(.ACC_WIDTH(ACC_W), .DATA_WIDTH(DW), .IDX_W(IW)) bus ();

   mlp_act_stage #(
      .ACC_WIDTH(ACC_W), .DATA_WIDTH(DW), .FRAC_BITS(8),
      .NUM_NEURONS(NN), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .bus          (bus.slave),
      .bias_wr_en   (bias_wr_en),
      .bias_wr_addr (bias_wr_addr),
      .bias_wr_data (bias_wr_data),
      .sat_count    (sat_count),
      .sat_clr      (sat_clr)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [IW-1:0] idx;
      logic          last;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   pops   = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_act(input longint s);
      longint r;
      if (s < 0) begin
`ifdef ACT_LEAKY_EN
         r = s >>> 3;
         if (r < -32768) r = -32768;
`else
         r = 0;
`endif
      end else if (s > 32767) begin
         r = 32767;
      end else begin
         r = s;
      end
      return r[DW-1:0];
   endfunction

   function automatic exp_t mk(input logic [DW-1:0] d, input int idx);
      exp_t e;
      e.data = d;
      e.idx  = IW'(idx);
      e.last = (idx == NN - 1);
      return e;
   endfunction

   // Monitor: samples between the falling edge and the next rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n && bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL pop_unexpected: got data %0d idx %0d, scoreboard empty",
                        bus.out_data, bus.out_idx);
            end else begin
               e = sb.pop_front();
               pops++;
               if (bus.out_data !== e.data || bus.out_idx !== e.idx || bus.out_last !== e.last) begin
                  errors++;
                  $display("FAIL pop%0d: got data %0d idx %0d last %0b expected data %0d idx %0d last %0b",
                           pops, bus.out_data, bus.out_idx, bus.out_last,
                           $signed(e.data), e.idx, e.last);
               end else begin
                  $display("pop %0d data %0d idx %0d last %0b", pops, bus.out_data, bus.out_idx, bus.out_last);
               end
            end
         end
      end
   end

   task automatic send(input longint acc, input int idx, input longint bias);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_acc   = acc;
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got in_ready 0 for %0d cycles, required 1", n);
      end else begin
         sb.push_back(mk(exp_act(acc + bias), idx));
         $display("send acc %0d idx %0d", acc, idx);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic bias_write(input int addr, input logic signed [DW-1:0] data);
      bias_wr_en   = 1'b1;
      bias_wr_addr = IW'(addr);
      bias_wr_data = data;
      @(negedge clk);
      bias_wr_en   = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || bus.out_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0 || bus.out_valid) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: got %0d entries pending, required 0", sb.size());
      end
   endtask

   initial begin
      int next;
      int n;
      int idx;
      longint tb_bias [NN];
      bus.in_valid  = 1'b0;
      bus.in_acc    = '0;
      bus.out_ready = 1'b0;

      // Reset state
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_idx", bus.out_idx, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_sat_count", sat_count, 0);

      // Basic bias + ReLU, latency and last flag
      bias_write(0, 256);
      bias_write(1, 0);
      bias_write(2, -128);
      bias_write(3, 512);
      bus.out_ready = 1'b1;
      send(1536, 0, 256);
      chk("lat_after_accept", bus.out_valid, 0);
      send(-1280, 1, 0);
      chk("lat_after_next_edge", bus.out_valid, 1);
      send(-2048, 2, -128);
      send(2560, 3, 512);
      drain();
      chk("t1_pops", pops, 4);
      chk("t1_sat_count", sat_count, 0);

      // Positive saturation and clear
      bias_write(0, 0);
      send(40000, 0, 0);
      drain();
      chk("sat_count_one", sat_count, 1);
      sat_clr = 1'b1;
      @(negedge clk);
      sat_clr = 1'b0;
      chk("sat_count_cleared", sat_count, 0);

      // Backpressure: FIFO fills to exactly DEPTH accepts and the head holds
      tb_bias = '{0, 0, -128, 512};
      bus.out_ready = 1'b0;
      next = 0;
      for (int c = 0; c < 8; c++) begin
         bus.in_valid = 1'b1;
         bus.in_acc   = 1000 + next * 10;
         if (bus.in_ready) begin
            idx = (1 + next) % NN;
            sb.push_back(mk(exp_act(1000 + next * 10 + tb_bias[idx]), idx));
            $display("send acc %0d idx %0d", 1000 + next * 10, idx);
            next++;
         end
         @(negedge clk);
         if (bus.out_valid) chk("bp_hold_data", bus.out_data, 1000);
      end
      chk("bp_accepts", next, 4);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      bus.out_ready = 1'b1;
      n = 0;
      while (next < 8 && n < 50) begin
         bus.in_valid = 1'b1;
         bus.in_acc   = 1000 + next * 10;
         if (bus.in_ready) begin
            idx = (1 + next) % NN;
            sb.push_back(mk(exp_act(1000 + next * 10 + tb_bias[idx]), idx));
            $display("send acc %0d idx %0d", 1000 + next * 10, idx);
            next++;
         end
         @(negedge clk);
         n++;
      end
      bus.in_valid = 1'b0;
      chk("bp_resume_accepts", next, 8);
      drain();
      chk("t3_pops", pops, 13);

      // Same-cycle bias write is not seen by the concurrent accept
      bus.in_valid = 1'b1;
      bus.in_acc   = 50;
      bias_wr_en   = 1'b1;
      bias_wr_addr = 2'd1;
      bias_wr_data = 16'sd100;
      chk("bw_in_ready", bus.in_ready, 1);
      sb.push_back(mk(16'd50, 1));
      $display("send acc 50 idx 1 with bias write 100");
      @(negedge clk);
      bias_wr_en   = 1'b0;
      bus.in_valid = 1'b0;
      send(200, 2, -128);
      send(0, 3, 512);
      send(10, 0, 0);
      send(50, 1, 100);
      drain();
      chk("t4_pops", pops, 18);

      // Asynchronous reset with 3 FIFO entries and stage 1 occupied
      bias_write(0, 256);
      bus.out_ready = 1'b0;
      send(10, 2, -128);
      send(20, 3, 512);
      send(30, 0, 256);
      send(40, 1, 100);
      chk("pre_rst_out_valid", bus.out_valid, 1);
      chk("pre_rst_in_ready", bus.in_ready, 0);
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", bus.out_valid, 0);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("post_rst_in_ready", bus.in_ready, 1);
      chk("post_rst_out_data", bus.out_data, 0);
      bus.out_ready = 1'b1;
      send(300, 0, 0);
      drain();
      chk("t5_pops", pops, 19);

      // Negative sum: zero for ReLU, sum>>>3 for leaky; never counted as saturation
      send(-800, 1, 0);
      drain();
      chk("neg_sat_count", sat_count, 0);
      chk("t6_pops", pops, 20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by time limit, required $finish");
      $fatal(1, "watchdog");
   end
endmodule
